// File: rtl/chisq_macc_sequencer.sv
// chisq_macc_sequencer
// Streams one track's chi components into the DSP48E chi-square MACC, drives
// its restart/accumulate control, waits out the MACC pipeline, then captures
// the chi-square and overflow flag and compares against a run-time threshold.
// Build macro: CHISQ_SATURATE_EN -- when defined, an overflowed result is
// reported as an all-ones chi-square instead of the wrapped MACC value.
//
// Handshakes (component input and result output): a transfer happens on a
// rising edge where valid and ready are both high; a raised valid holds its
// payload until that edge; ready depends only on state, never on same-cycle
// valid.
module chisq_macc_sequencer #(
    parameter int PARAMETERWIDTH = 15,
    parameter int CHISQBITS      = 32,
    parameter int NCOMP_MAX      = 8,
    parameter int MACC_LATENCY   = 3
) (
    input  logic                      CLK_IN,
    input  logic                      RESET_N,
    input  logic [PARAMETERWIDTH-1:0] COMP_IN,
    input  logic                      COMP_VALID_IN,
    input  logic                      COMP_LAST_IN,
    output logic                      COMP_READY_OUT,
    input  logic [CHISQBITS-1:0]      THRESH_IN,
    output logic [PARAMETERWIDTH-1:0] CHI_OUT,
    output logic                      LOAD_OUT,
    output logic                      MACC_RST_OUT,
    input  logic [CHISQBITS-1:0]      P_IN,
    input  logic                      OVERFLOW_IN,
    output logic [CHISQBITS-1:0]      CHISQ_OUT,
    output logic                      PASS_OUT,
    output logic                      OVF_OUT,
    output logic                      TRUNC_OUT,
    output logic                      CHISQ_VALID_OUT,
    input  logic                      CHISQ_READY_IN,
    output logic [1:0]                DBG_STATE_OUT
);

    localparam int CW = $clog2(NCOMP_MAX + 1);
    localparam int WW = $clog2(MACC_LATENCY + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              count_q;
    logic [WW-1:0]              drain_cnt_q;
    logic [PARAMETERWIDTH-1:0]  chi_q;
    logic                       first_q;
    logic                       load_q;
    logic                       macc_rst_q;
    logic [CHISQBITS-1:0]       chisq_q;
    logic                       pass_q;
    logic                       ovf_q;
    logic                       trunc_q;
    logic                       valid_q;
    logic                       comp_ready;
    logic                       accept;
    logic                       end_of_track;
    logic                       capture;
    logic [CHISQBITS-1:0]       chisq_cap;

    // Components are taken only while feeding and never while the MACC is in reset.
    assign comp_ready   = ((state_q == S_IDLE) || (state_q == S_FEED)) && !macc_rst_q;
    assign accept       = COMP_VALID_IN && comp_ready;
    assign end_of_track = COMP_LAST_IN || (count_q == CW'(NCOMP_MAX - 1));
    // The final CHI_OUT cycle is followed by MACC_LATENCY cycles plus one for the
    // opmode/datapath skew before P_IN holds the finished sum.
    assign capture      = (state_q == S_DRAIN) && (drain_cnt_q == WW'(MACC_LATENCY + 1));

`ifdef CHISQ_SATURATE_EN
    assign chisq_cap = OVERFLOW_IN ? {CHISQBITS{1'b1}} : P_IN;
`else
    assign chisq_cap = P_IN;
`endif

    // MACC reset is the registered inverse of RESET_N.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) macc_rst_q <= 1'b1;
        else          macc_rst_q <= 1'b0;
    end

    // State register plus datapath, counters and result capture.
    always_ff @(posedge CLK_IN) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            drain_cnt_q <= '0;
            chi_q       <= '0;
            first_q     <= 1'b0;
            load_q      <= 1'b0;
            chisq_q     <= '0;
            pass_q      <= 1'b0;
            ovf_q       <= 1'b0;
            trunc_q     <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            // Idle-fill cycles present 0 so the MACC accumulates nothing.
            chi_q   <= accept ? COMP_IN : '0;
            // LOAD trails CHI by one cycle: restart only on the track's first component.
            first_q <= accept && (count_q == '0);
            load_q  <= !first_q;
            if (accept) begin
                if (end_of_track) begin
                    count_q <= '0;
                    trunc_q <= !COMP_LAST_IN;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end
            if (state_q == S_DRAIN) drain_cnt_q <= drain_cnt_q + WW'(1);
            else                    drain_cnt_q <= '0;
            if (capture) begin
                chisq_q <= chisq_cap;
                ovf_q   <= OVERFLOW_IN;
                pass_q  <= !OVERFLOW_IN && (P_IN <= THRESH_IN);
                valid_q <= 1'b1;
            end
            if ((state_q == S_HOLD) && CHISQ_READY_IN) begin
                valid_q <= 1'b0;
                trunc_q <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_FEED: if (accept) state_d = end_of_track ? S_DRAIN : S_FEED;
            S_DRAIN:        if (capture) state_d = S_HOLD;
            S_HOLD:         if (CHISQ_READY_IN) state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
    end

    assign COMP_READY_OUT  = comp_ready;
    assign CHI_OUT         = chi_q;
    assign LOAD_OUT        = load_q;
    assign MACC_RST_OUT    = macc_rst_q;
    assign CHISQ_OUT       = chisq_q;
    assign PASS_OUT        = pass_q;
    assign OVF_OUT         = ovf_q;
    assign TRUNC_OUT       = trunc_q;
    assign CHISQ_VALID_OUT = valid_q;
    assign DBG_STATE_OUT   = state_q;

endmodule
